// File: rtl/sel_f2cpu_if.sv
// FTDI FT60x read-side bus plus CPU valid/ready stream for sel_f2cpu.
// master: the selector (drives OE_N/RD_N and the CPU stream); slave: FTDI chip and CPU side.
interface sel_f2cpu_if #(
    parameter int FT_DATA_WIDTH = 32
);
    logic                     ft_rxf_n;
    logic [FT_DATA_WIDTH-1:0] ft_data;
    logic [3:0]               ft_be;
    logic                     ft_oe_n;
    logic                     ft_rd_n;
    logic [FT_DATA_WIDTH-1:0] cpu_data;
    logic                     cpu_valid;
    logic                     cpu_ready;

    modport master (
        input  ft_rxf_n, ft_data, ft_be, cpu_ready,
        output ft_oe_n, ft_rd_n, cpu_data, cpu_valid
    );

    modport slave (
        output ft_rxf_n, ft_data, ft_be, cpu_ready,
        input  ft_oe_n, ft_rd_n, cpu_data, cpu_valid
    );
endinterface

// File: rtl/sel_f2cpu.sv
// FTDI FT60x 245-sync read engine feeding the CPU through a first-word fall-through skid FIFO.
// Optional byte-enable filtering of captured words when SEL_F2CPU_BE_FILTER_EN is defined.
module sel_f2cpu #(
    parameter int FT_DATA_WIDTH = 32,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        en_i,
    sel_f2cpu_if.master bus,
    output logic [15:0] rx_cnt_o,
    output logic        busy_o
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_OE, S_READ, S_DRAIN} state_t;

    state_t                   state_q, state_d;
    logic                     oe_n_q, rd_n_q;
    logic [FT_DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]         wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]         count_q;
    logic                     space_ok, capture, push, pop, fifo_valid;
    logic [FT_DATA_WIDTH-1:0] push_data;

    // Two free entries cover the word captured on the edge the FSM leaves READ.
    assign space_ok   = count_q < CNT_W'(FIFO_DEPTH - 1);
    assign capture    = !rd_n_q && !bus.ft_rxf_n;
    assign fifo_valid = count_q != '0;
    assign pop        = fifo_valid && bus.cpu_ready;

`ifdef SEL_F2CPU_BE_FILTER_EN
    localparam int LANE_W = FT_DATA_WIDTH / 4;

    always_comb begin
        push_data = '0;
        for (int i = 0; i < 4; i++) begin
            if (bus.ft_be[i]) push_data[i*LANE_W +: LANE_W] = bus.ft_data[i*LANE_W +: LANE_W];
        end
    end
    assign push = capture && (bus.ft_be != 4'b0000);
`else
    logic be_unused;
    assign be_unused = ^bus.ft_be;
    assign push_data = bus.ft_data;
    assign push      = capture;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (en_i && !bus.ft_rxf_n && space_ok) state_d = S_OE;
            S_OE:    state_d = (!bus.ft_rxf_n && en_i) ? S_READ : S_DRAIN;
            S_READ:  if (bus.ft_rxf_n || !space_ok || !en_i) state_d = S_DRAIN;
            S_DRAIN: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Strobes are registered from the next state so the pins change cleanly on the edge.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= S_IDLE;
            oe_n_q  <= 1'b1;
            rd_n_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            oe_n_q  <= (state_d == S_IDLE);
            rd_n_q  <= (state_d != S_READ);
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rx_cnt_o <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                rx_cnt_o <= rx_cnt_o + 16'd1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (push && !pop)      count_q <= count_q + CNT_W'(1);
            else if (pop && !push) count_q <= count_q - CNT_W'(1);
        end
    end

    // NOTE: the storage array has no reset; an empty FIFO masks its output to zero instead.
    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr_q] <= push_data;
    end

    assign bus.ft_oe_n   = oe_n_q;
    assign bus.ft_rd_n   = rd_n_q;
    assign bus.cpu_valid = fifo_valid;
    assign bus.cpu_data  = fifo_valid ? mem[rd_ptr_q] : '0;
    assign busy_o        = state_q != S_IDLE;
endmodule

// File: tb/tb_sel_f2cpu.sv
// Scoreboard bench for sel_f2cpu: a host FIFO model feeds words, expected words queue on capture.
// Expected values follow the build: SEL_F2CPU_BE_FILTER_EN changes the byte-enable test.
module tb_sel_f2cpu;
    localparam int W     = 32;
    localparam int DEPTH = 4;

    typedef struct {
        logic [W-1:0] data;
        logic [3:0]   be;
        int           gap;
    } beat_t;

    logic        clk = 1'b0;
    logic        rstn;
    logic        en;
    logic [15:0] rx_cnt;
    logic        busy;

    sel_f2cpu_if #(.FT_DATA_WIDTH(W)) bus ();

    sel_f2cpu #(.FT_DATA_WIDTH(W), .FIFO_DEPTH(DEPTH)) dut (
        .clk_i    (clk),
        .rstn_i   (rstn),
        .en_i     (en),
        .bus      (bus.master),
        .rx_cnt_o (rx_cnt),
        .busy_o   (busy)
    );

    always #5 clk = ~clk;

    beat_t        host_q[$];
    logic [W-1:0] exp_q[$];
    int           n_cmp = 0;
    int           n_err = 0;
    int           cyc = 0;
    logic         ready_en = 1'b0;
    int           acc_n, first_acc, last_acc;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    function automatic logic [W-1:0] be_mask(input logic [W-1:0] d, input logic [3:0] be);
        logic [W-1:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = be[i] ? d[8*i +: 8] : 8'h00;
        return r;
    endfunction

    // Host and CPU side, all driven on the falling edge; the DUT samples on the rising edge.
    initial begin
        logic  pending;
        beat_t b;
        pending       = 1'b0;
        bus.ft_rxf_n  = 1'b1;
        bus.ft_data   = '0;
        bus.ft_be     = 4'hF;
        bus.cpu_ready = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rstn) begin
                host_q.delete();
                exp_q.delete();
                pending       = 1'b0;
                bus.ft_rxf_n  = 1'b1;
                bus.cpu_ready = 1'b0;
            end else begin
                if (pending) begin
                    b = host_q.pop_front();
`ifdef SEL_F2CPU_BE_FILTER_EN
                    if (b.be != 4'b0000) exp_q.push_back(be_mask(b.data, b.be));
`else
                    exp_q.push_back(b.data);
`endif
                end
                if (host_q.size() != 0 && host_q[0].gap > 0) begin
                    b = host_q[0];
                    b.gap--;
                    host_q[0] = b;
                    bus.ft_rxf_n = 1'b1;
                    bus.ft_data  = 32'hDEAD_BEEF;
                end else if (host_q.size() != 0) begin
                    bus.ft_rxf_n = 1'b0;
                    bus.ft_data  = host_q[0].data;
                    bus.ft_be    = host_q[0].be;
                end else begin
                    bus.ft_rxf_n = 1'b1;
                    bus.ft_data  = 32'hDEAD_BEEF;
                end
                bus.cpu_ready = ready_en;
                if (bus.cpu_valid && bus.cpu_ready) begin
                    if (exp_q.size() == 0) begin
                        check("spurious_word", {31'd0, bus.cpu_valid}, 32'd0);
                    end else begin
                        check("cpu_data", bus.cpu_data, exp_q.pop_front());
                        if (acc_n == 0) first_acc = cyc;
                        last_acc = cyc;
                        acc_n++;
                    end
                end
                pending = !bus.ft_rd_n && !bus.ft_rxf_n;
                if (exp_q.size() > DEPTH) check("fifo_overflow", exp_q.size(), DEPTH);
            end
        end
    end

    task automatic push_beat(input logic [W-1:0] d, input logic [3:0] be, input int gap);
        beat_t b;
        b.data = d;
        b.be   = be;
        b.gap  = gap;
        host_q.push_back(b);
    endtask

    task automatic clear_acc();
        acc_n     = 0;
        first_acc = 0;
        last_acc  = 0;
    endtask

    // Wait until the host is drained, the FSM is idle and (if the CPU is accepting) the FIFO is empty.
    task automatic wait_done(input string tag, input int budget, output int idle_gap);
        int  n;
        logic done;
        n        = 0;
        idle_gap = 0;
        done     = 1'b0;
        while (!done && n < budget) begin
            @(negedge clk);
            #1;
            n++;
            if (!busy && host_q.size() != 0) idle_gap++;
            done = host_q.size() == 0 && !busy && (!ready_en || exp_q.size() == 0) && n > 2;
        end
        check({tag, "_done"}, {31'd0, done}, 32'd1);
    endtask

    initial begin
        int gap;
        int n;
        rstn = 1'b1;
        en   = 1'b0;
        clear_acc();
        #1 rstn = 1'b0;
        #1;
        check("rst_oe_n", {31'd0, bus.ft_oe_n}, 32'd1);
        check("rst_rd_n", {31'd0, bus.ft_rd_n}, 32'd1);
        check("rst_valid", {31'd0, bus.cpu_valid}, 32'd0);
        check("rst_data", bus.cpu_data, 32'd0);
        check("rst_rx_cnt", {16'd0, rx_cnt}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        repeat (3) @(negedge clk);
        #2 rstn = 1'b1;

        // Single word, CPU not accepting yet.
        en = 1'b1;
        push_beat(32'hA5A5_0001, 4'hF, 0);
        wait_done("single", 100, gap);
        check("single_rx_cnt", {16'd0, rx_cnt}, 32'd1);
        check("single_valid", {31'd0, bus.cpu_valid}, 32'd1);
        check("single_data", bus.cpu_data, 32'hA5A5_0001);
        check("single_oe_n", {31'd0, bus.ft_oe_n}, 32'd1);
        ready_en = 1'b1;
        wait_done("single_pop", 100, gap);
        check("single_empty", {31'd0, bus.cpu_valid}, 32'd0);

        // Streaming burst with the CPU always ready.
        clear_acc();
        for (int i = 0; i < 10; i++) push_beat(32'(i), 4'hF, 0);
        wait_done("burst", 200, gap);
        check("burst_rx_cnt", {16'd0, rx_cnt}, 32'd11);
        check("burst_count", acc_n, 10);
        check("burst_no_gap", last_acc - first_acc, 9);

        // Backpressure: FIFO fills to its depth and the engine parks in IDLE.
        ready_en = 1'b0;
        clear_acc();
        for (int i = 0; i < 10; i++) push_beat(32'h100 + 32'(i), 4'hF, 0);
        repeat (30) @(negedge clk);
        #1;
        check("bp_fifo_level", exp_q.size(), DEPTH);
        check("bp_host_left", host_q.size(), 6);
        check("bp_rd_n", {31'd0, bus.ft_rd_n}, 32'd1);
        check("bp_busy", {31'd0, busy}, 32'd0);
        check("bp_rx_cnt", {16'd0, rx_cnt}, 32'd15);
        check("bp_head", bus.cpu_data, 32'h100);
        @(negedge clk);
        #1;
        check("bp_head_stable", bus.cpu_data, 32'h100);
        ready_en = 1'b1;
        wait_done("bp", 300, gap);
        check("bp_count", acc_n, 10);
        check("bp_rx_cnt_end", {16'd0, rx_cnt}, 32'd21);

        // Host stalls for three cycles after the third word.
        clear_acc();
        for (int i = 0; i < 8; i++) push_beat(32'h200 + 32'(i), 4'hF, (i == 3) ? 3 : 0);
        wait_done("stall", 200, gap);
        check("stall_reentry", {31'd0, gap != 0}, 32'd1);
        check("stall_count", acc_n, 8);
        check("stall_rx_cnt", {16'd0, rx_cnt}, 32'd29);

        // Byte enables: all-off word, partial word, full word.
        clear_acc();
        push_beat(32'hCAFE_0000, 4'b0000, 0);
        push_beat(32'h1122_3344, 4'b0101, 0);
        push_beat(32'h5566_7788, 4'b1111, 0);
        wait_done("be", 200, gap);
`ifdef SEL_F2CPU_BE_FILTER_EN
        check("be_count", acc_n, 2);
        check("be_rx_cnt", {16'd0, rx_cnt}, 32'd31);
`else
        check("be_count", acc_n, 3);
        check("be_rx_cnt", {16'd0, rx_cnt}, 32'd32);
`endif

        // Engine disabled: host data waits, then drains once enabled.
        en = 1'b0;
        push_beat(32'h300, 4'hF, 0);
        repeat (10) @(negedge clk);
        #1;
        check("dis_busy", {31'd0, busy}, 32'd0);
        check("dis_host_left", host_q.size(), 1);
        en = 1'b1;
        wait_done("dis", 100, gap);

        // Asynchronous reset in the middle of a read burst.
        ready_en = 1'b0;
        for (int i = 0; i < 8; i++) push_beat(32'h400 + 32'(i), 4'hF, 0);
        n = 0;
        while (bus.ft_rd_n && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        @(negedge clk);
        #2;
        check("ar_in_read", {31'd0, bus.ft_rd_n}, 32'd0);
        rstn = 1'b0;
        #1;
        check("ar_rd_n", {31'd0, bus.ft_rd_n}, 32'd1);
        check("ar_oe_n", {31'd0, bus.ft_oe_n}, 32'd1);
        check("ar_valid", {31'd0, bus.cpu_valid}, 32'd0);
        check("ar_data", bus.cpu_data, 32'd0);
        check("ar_rx_cnt", {16'd0, rx_cnt}, 32'd0);
        check("ar_busy", {31'd0, busy}, 32'd0);
        repeat (3) @(negedge clk);
        #2 rstn = 1'b1;
        ready_en = 1'b1;
        clear_acc();
        push_beat(32'h500, 4'hF, 0);
        wait_done("ar_after", 100, gap);
        check("ar_after_count", acc_n, 1);
        check("ar_after_rx_cnt", {16'd0, rx_cnt}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
